// File: rtl/pc_fetch.sv
// Instruction fetch sequencer: issues one memory read per instruction, holds the
// fetched word for execute, then advances the program counter.
module pc_fetch #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    // Value the retired counter takes on reset; 0 in normal use.
    parameter logic [15:0] RETIRED_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        jmp,
    input  logic        incr,
    input  logic [15:0] target,
    output logic [15:0] pc,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {FETCH, WAIT_ACK, EXEC} stateT;

    stateT       state;
    stateT       stateNext;
    logic [15:0] pcNext;
    logic        ackTaken;
    logic        retire;

    assign ackTaken = (state == WAIT_ACK) && mem_ack;
    assign retire   = (state == EXEC) && exec_done;
    assign mem_addr = pc;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        mem_req   = 1'b0;
        case (state)
            FETCH: begin
                if (run) stateNext = WAIT_ACK;
            end
            WAIT_ACK: begin
                mem_req = 1'b1;
                if (mem_ack) stateNext = EXEC;
            end
            EXEC: begin
                if (exec_done) begin
                    stateNext = FETCH;
                    // jmp wins over incr; neither means re-fetch the same word
                    if (jmp)       pcNext = target;
                    else if (incr) pcNext = pc + 16'd1;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_valid <= 1'b0;
            retired     <= RETIRED_INIT;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            if (ackTaken) begin
                instr       <= mem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                instr_valid <= 1'b0;
                retired     <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch; a second instance with a preloaded retired
// counter shares all inputs so the counter wrap is reachable quickly.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst, run, mem_ack, exec_done, jmp, incr;
    logic [15:0] mem_rdata, target;
    logic        mem_req, instr_valid;
    logic [15:0] mem_addr, instr, pc, retired;
    logic        memReq2, instrValid2;
    logic [15:0] memAddr2, instr2, pc2, retired2;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .jmp(jmp), .incr(incr), .target(target), .pc(pc),
        .retired(retired)
    );

    pc_fetch #(.RESET_PC(16'h0000), .RETIRED_INIT(16'hFFFE)) dutWrap (
        .clk(clk), .rst(rst), .run(run), .mem_req(memReq2), .mem_addr(memAddr2),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr2), .instr_valid(instrValid2),
        .exec_done(exec_done), .jmp(jmp), .incr(incr), .target(target), .pc(pc2),
        .retired(retired2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; run = 0; mem_ack = 0; exec_done = 0; jmp = 0; incr = 0;
        mem_rdata = 16'h0000; target = 16'h0000;
    endtask

    // One full instruction from FETCH with single-cycle ack and exec_done.
    task automatic doInstr(input logic [15:0] rd, input logic j, input logic i, input logic [15:0] tg);
        run = 1; step();
        run = 0; mem_ack = 1; mem_rdata = rd; step();
        mem_ack = 0; exec_done = 1; jmp = j; incr = i; target = tg; step();
        exec_done = 0; jmp = 0; incr = 0;
    endtask

    task automatic test_reset();
        rst = 1; run = 1; mem_ack = 1; exec_done = 1; jmp = 1; incr = 1;
        mem_rdata = 16'hFFFF; target = 16'h5555;
        step(); step();
        idle();
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (retired !== 16'h0000) begin bad++; $display("FAIL reset_retired got=%h exp=0000", retired); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_basic();
        run = 1; step();
        run = 0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL basic_req got=%b exp=1", mem_req); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("FAIL basic_addr got=%h exp=0000", mem_addr); end
        mem_ack = 1; mem_rdata = 16'h1234; step();
        mem_ack = 0;
        total++; if (instr !== 16'h1234) begin bad++; $display("FAIL basic_instr got=%h exp=1234", instr); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", instr_valid); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL basic_exec_req got=%b exp=0", mem_req); end
        exec_done = 1; incr = 1; step();
        exec_done = 0; incr = 0;
        total++; if (pc !== 16'h0001) begin bad++; $display("FAIL basic_pc got=%h exp=0001", pc); end
        total++; if (retired !== 16'h0001) begin bad++; $display("FAIL basic_retired got=%h exp=0001", retired); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_clr got=%b exp=0", instr_valid); end
    endtask

    task automatic test_wait_states();
        run = 1; step();
        for (int c = 0; c < 4; c++) begin
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wait_req cyc=%0d got=%b exp=1", c, mem_req); end
            total++; if (mem_addr !== 16'h0001) begin bad++; $display("FAIL wait_addr cyc=%0d got=%h exp=0001", c, mem_addr); end
            run = (c % 2 == 0) ? 1'b0 : 1'b1;
            if (c < 3) step();
        end
        mem_ack = 1; mem_rdata = 16'h5555; step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wait_exec_req got=%b exp=0", mem_req); end
        total++; if (instr !== 16'h5555) begin bad++; $display("FAIL wait_instr got=%h exp=5555", instr); end
        // ack while executing must not overwrite instr
        mem_rdata = 16'hBEEF; run = 0; step();
        mem_ack = 0;
        total++; if (instr !== 16'h5555) begin bad++; $display("FAIL exec_ack_ignored got=%h exp=5555", instr); end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL exec_valid_hold got=%b exp=1", instr_valid); end
        exec_done = 1; incr = 1; step();
        // exec_done in FETCH must be ignored
        incr = 0; jmp = 1; target = 16'h7777; step();
        exec_done = 0; jmp = 0;
        total++; if (pc !== 16'h0002) begin bad++; $display("FAIL fetch_exec_ignored_pc got=%h exp=0002", pc); end
        total++; if (retired !== 16'h0002) begin bad++; $display("FAIL fetch_exec_ignored_ret got=%h exp=0002", retired); end
    endtask

    task automatic test_jump_priority();
        doInstr(16'h1111, 1'b1, 1'b1, 16'hABCD);
        total++; if (pc !== 16'hABCD) begin bad++; $display("FAIL jump_pc got=%h exp=abcd", pc); end
        run = 1; step();
        run = 0;
        total++; if (mem_addr !== 16'hABCD) begin bad++; $display("FAIL jump_addr got=%h exp=abcd", mem_addr); end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL jump_req got=%b exp=1", mem_req); end
        mem_ack = 1; step();
        mem_ack = 0; exec_done = 1; incr = 1; step();
        exec_done = 0; incr = 0;
        total++; if (pc !== 16'hABCE) begin bad++; $display("FAIL jump_incr_pc got=%h exp=abce", pc); end
    endtask

    task automatic test_no_update();
        doInstr(16'h2222, 1'b0, 1'b0, 16'h9999);
        total++; if (pc !== 16'hABCE) begin bad++; $display("FAIL noupd_pc got=%h exp=abce", pc); end
        total++; if (retired !== 16'h0005) begin bad++; $display("FAIL noupd_retired got=%h exp=0005", retired); end
        run = 1; step();
        run = 0;
        total++; if (mem_addr !== 16'hABCE) begin bad++; $display("FAIL noupd_refetch got=%h exp=abce", mem_addr); end
    endtask

    task automatic test_wrap();
        rst = 1; step();
        rst = 0;
        total++; if (retired2 !== 16'hFFFE) begin bad++; $display("FAIL wrap_ret_init got=%h exp=fffe", retired2); end
        doInstr(16'h0000, 1'b1, 1'b0, 16'hFFFF);
        total++; if (pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_pc_pre got=%h exp=ffff", pc); end
        total++; if (retired2 !== 16'hFFFF) begin bad++; $display("FAIL wrap_ret_pre got=%h exp=ffff", retired2); end
        doInstr(16'h0000, 1'b0, 1'b1, 16'h0000);
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
        total++; if (retired2 !== 16'h0000) begin bad++; $display("FAIL wrap_ret got=%h exp=0000", retired2); end
        total++; if (retired !== 16'h0002) begin bad++; $display("FAIL wrap_ret_main got=%h exp=0002", retired); end
    endtask

    task automatic test_reset_mid_fetch();
        doInstr(16'h0000, 1'b1, 1'b0, 16'h0042);
        run = 1; step();
        total++; if (mem_addr !== 16'h0042) begin bad++; $display("FAIL midrst_addr got=%h exp=0042", mem_addr); end
        rst = 1; mem_ack = 1; mem_rdata = 16'hDEAD; exec_done = 1; step();
        rst = 0; run = 0; exec_done = 0;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b exp=0", mem_req); end
        total++; if (pc !== 16'h0000) begin bad++; $display("FAIL midrst_pc got=%h exp=0000", pc); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL midrst_instr got=%h exp=0000", instr); end
        total++; if (retired !== 16'h0000) begin bad++; $display("FAIL midrst_retired got=%h exp=0000", retired); end
        step();
        mem_ack = 0;
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL stray_ack_instr got=%h exp=0000", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stray_ack_valid got=%b exp=0", instr_valid); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL stray_ack_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_back_to_back();
        run = 1; mem_ack = 1; mem_rdata = 16'h0F0F; exec_done = 1; incr = 1;
        repeat (9) step();
        idle();
        total++; if (pc !== 16'h0003) begin bad++; $display("FAIL b2b_pc got=%h exp=0003", pc); end
        total++; if (retired !== 16'h0003) begin bad++; $display("FAIL b2b_retired got=%h exp=0003", retired); end
        total++; if (instr !== 16'h0F0F) begin bad++; $display("FAIL b2b_instr got=%h exp=0f0f", instr); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_req got=%b exp=0", mem_req); end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_wait_states();
        test_jump_priority();
        test_no_update();
        test_wrap();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the program counter value loaded on reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port run  input  1  fetch enable; a new fetch is issued only while high.
REQ-005 SHALL have port mem_req  output  1  instruction memory read request.
REQ-006 SHALL have port mem_addr  output  16  instruction word address, equal to pc.
REQ-007 SHALL have port mem_ack  input  1  memory read complete; mem_rdata is valid in the same cycle.
REQ-008 SHALL have port mem_rdata  input  16  instruction word read from memory.
REQ-009 SHALL have port instr  output  16  instruction register contents, presented to decode and the jump-condition unit.
REQ-010 SHALL have port instr_valid  output  1  instr holds a fetched instruction awaiting execution.
REQ-011 SHALL have port exec_done  input  1  execute stage is complete; jmp, incr and target are sampled in this cycle.
REQ-012 SHALL have port jmp  input  1  jump-condition result, meaning load target into pc.
REQ-013 SHALL have port incr  input  1  jump-condition result, meaning advance pc by one.
REQ-014 SHALL have port target  input  16  jump destination address.
REQ-015 SHALL have port pc  output  16  current program counter.
REQ-016 SHALL have port retired  output  16  count of completed instructions, wrapping modulo 2^16.

Function
REQ-017 SHALL implement a state machine with states FETCH, WAIT_ACK and EXEC.
REQ-018 SHALL assert mem_req combinationally in WAIT_ACK only; mem_addr SHALL equal pc at all times.
REQ-019 SHALL, in FETCH with run=1, enter WAIT_ACK on the next cycle; with run=0, remain in FETCH with mem_req=0.
REQ-020 SHALL, in WAIT_ACK, hold mem_req=1 and mem_addr stable until mem_ack=1, regardless of run.
REQ-021 SHALL, on a cycle with WAIT_ACK and mem_ack=1, capture mem_rdata into instr and enter EXEC; instr_valid SHALL be 1 from the next cycle.
REQ-022 SHALL ignore mem_ack in FETCH and EXEC, leaving instr unchanged.
REQ-023 SHALL hold instr and instr_valid=1 throughout EXEC, and ignore exec_done outside EXEC.
REQ-024 SHALL, on EXEC with exec_done=1, update pc, increment retired, clear instr_valid and return to FETCH on the next cycle.
REQ-025 SHALL apply the pc update as follows: jmp=1 loads target; otherwise incr=1 loads pc+1; both 0 leaves pc unchanged, so the same address is re-fetched.
REQ-026 SHALL give jmp priority when jmp=1 and incr=1 in the same cycle.
REQ-027 SHALL wrap pc+1 from 16'hFFFF to 16'h0000 with no flag or stall.
REQ-028 SHALL wrap retired from 16'hFFFF to 16'h0000.
REQ-029 SHALL need a minimum of 3 cycles per instruction: FETCH, WAIT_ACK with same-cycle ack, then EXEC with same-cycle exec_done.

Reset
REQ-030 SHALL, on a clock edge with rst=1, set the state to FETCH, pc=RESET_PC, instr=16'h0000, instr_valid=0 and retired=0.
REQ-031 SHALL deassert mem_req in the cycle after rst is sampled high, even when reset arrives mid-WAIT_ACK; any later mem_ack for the aborted request SHALL be ignored.
REQ-032 SHALL give rst priority over mem_ack, exec_done and run in the same cycle.

Verification
REQ-033 SHALL verify the basic fetch: reset, run=1, mem_ack on the 1st request cycle with rdata=16'h1234 -> mem_addr=0000, instr=1234 with instr_valid=1; exec_done with incr=1 -> pc=0001, retired=1.
REQ-034 SHALL verify memory wait states: ack delayed 3 cycles -> mem_req stays 1 for 4 cycles and mem_addr stays constant; toggling run during the wait has no effect.
REQ-035 SHALL verify jump priority: exec_done with jmp=1, incr=1, target=16'hABCD -> pc=ABCD and the next mem_addr=ABCD.
REQ-036 SHALL verify wrap-around: pc=FFFF, exec_done with incr=1 -> pc=0000; retired=FFFF then one more completion -> retired=0000.
REQ-037 SHALL verify the no-update case: exec_done with jmp=0, incr=0 -> pc unchanged and the same address is re-requested.
REQ-038 SHALL verify reset mid-fetch: rst during WAIT_ACK -> mem_req=0 next cycle, pc=RESET_PC; a later stray mem_ack leaves instr=0000 and instr_valid=0.
